imm_operand_encoder: RTL and testbench

- Inverse of the Val2 immediate path: takes a 32-bit constant and searches for the ARM data-processing rotated-immediate encoding {rotate_imm[3:0], imm8[7:0]}, where value = ROR(imm8, 2*rotate_imm).
- Sits beside the decode/assembler-support logic and generates shifter_operand fields for constants.
- Sequential search tests one rotation per clock behind a start/done handshake.
- Reports whether the constant is encodable.

---
 rtl/imm_operand_encoder.sv | 114 +++++++++++
 tb/tb_imm_operand_encoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/imm_operand_encoder.sv
// Searches for the ARM rotated-immediate encoding {rotate_imm, imm8} of a 32-bit constant, one rotation per clock.
// Optional macro IMM_ENC_FAST_PATH_EN: values that already fit in imm8 skip SEARCH and finish one cycle earlier.
module imm_operand_encoder #(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned OPERAND_WIDTH = 12,
  parameter int unsigned ROT_STEPS     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WORD_WIDTH-1:0]    value_in,
  output logic                     busy,
  output logic                     done,
  output logic                     valid,
  output logic [OPERAND_WIDTH-1:0] shifter_operand_out
);

  localparam int unsigned ROT_W = $clog2(ROT_STEPS);
  localparam int unsigned IMM_W = OPERAND_WIDTH - ROT_W;
  localparam int unsigned SH_W  = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [WORD_WIDTH-1:0]    val_q, val_d;
  logic [ROT_W-1:0]         r_q, r_d;
  logic                     valid_q, valid_d;
  logic [OPERAND_WIDTH-1:0] op_q, op_d;

  logic [SH_W-1:0]          sh;
  logic [WORD_WIDTH-1:0]    cand;
  logic                     hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      op_q    <= op_d;
    end
  end

  // Rotate left by 2*r; a shift by the full word width yields zero, so r=0 is a plain copy.
  always_comb begin
    sh   = {r_q, 1'b0};
    cand = (val_q << sh) | (val_q >> (WORD_WIDTH - sh));
    hit  = (cand[WORD_WIDTH-1:IMM_W] == '0);
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    r_d     = r_q;
    valid_d = valid_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          val_d   = value_in;
          r_d     = '0;
          valid_d = 1'b0;
          op_d    = '0;
`ifdef IMM_ENC_FAST_PATH_EN
          if (value_in[WORD_WIDTH-1:IMM_W] == '0) begin
            valid_d = 1'b1;
            op_d    = {{ROT_W{1'b0}}, value_in[IMM_W-1:0]};
            state_d = S_DONE;
          end else begin
            state_d = S_SEARCH;
          end
`else
          state_d = S_SEARCH;
`endif
        end
      end
      S_SEARCH: begin
        if (hit) begin
          op_d    = {r_q, cand[IMM_W-1:0]};
          valid_d = 1'b1;
          state_d = S_DONE;
        end else if (r_q == ROT_W'(ROT_STEPS - 1)) begin
          op_d    = '0;
          valid_d = 1'b0;
          state_d = S_DONE;
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy                = (state_q == S_SEARCH);
  assign done                = (state_q == S_DONE);
  assign valid               = valid_q;
  assign shifter_operand_out = op_q;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Directed bench for imm_operand_encoder: a latency/result model checked every cycle, plus hand-computed expectations.
module tb_imm_operand_encoder;

`ifdef IMM_ENC_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value_in = '0;
  logic        busy, done, valid;
  logic [11:0] shifter_operand_out;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  imm_operand_encoder #(
    .WORD_WIDTH(32),
    .OPERAND_WIDTH(12),
    .ROT_STEPS(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .value_in(value_in),
    .busy(busy),
    .done(done),
    .valid(valid),
    .shifter_operand_out(shifter_operand_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Smallest r with value == ROR(imm8, 2r), imm8 taken as the low byte of the value rotated back.
  function automatic void model_encode(input logic [31:0] v, output bit ok,
                                       output logic [11:0] op, output int rr);
    logic [63:0] t;
    logic [31:0] back;
    logic [7:0]  imm;
    ok = 1'b0; op = '0; rr = 15;
    for (int r = 15; r >= 0; r--) begin
      t    = {v, v} << (2 * r);
      imm  = t[39:32];
      t    = {24'h0, imm, 24'h0, imm} >> (2 * r);
      back = t[31:0];
      if (back == v) begin
        ok = 1'b1; rr = r; op = {r[3:0], imm};
      end
    end
  endfunction

  bit          m_busy, m_done, m_valid, res_ok;
  logic [11:0] m_op, res_op;
  int          m_left;

  always @(posedge clk) begin
    bit          ok;
    logic [11:0] op;
    int          rr;
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_valid <= 0; m_op <= '0; m_left <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 0; m_done <= 1; m_valid <= res_ok; m_op <= res_op;
      end
      m_left <= m_left - 1;
    end else if (m_done) begin
      m_done <= 0;
    end else if (start) begin
      model_encode(value_in, ok, op, rr);
      if (FAST && value_in < 32'd256) begin
        m_done <= 1; m_valid <= 1; m_op <= {4'h0, value_in[7:0]};
      end else begin
        m_busy <= 1; m_valid <= 0; m_op <= '0;
        m_left <= ok ? rr + 1 : 16;
        res_ok <= ok; res_op <= ok ? op : 12'h000;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model busy",  {31'h0, busy},  {31'h0, m_busy});
      chk("model done",  {31'h0, done},  {31'h0, m_done});
      chk("model valid", {31'h0, valid}, {31'h0, m_valid});
      chk("model operand", {20'h0, shifter_operand_out}, {20'h0, m_op});
    end
  end

  // Counts negedges from the one after the accepting edge E0 until done is seen.
  task automatic run(input logic [31:0] v, input logic [11:0] eo, input bit ev,
                     input int elat, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1; value_in = v;
    @(negedge clk);
    start = 1'b0; value_in = ~v;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, elat);
    chk({nm, " operand"}, {20'h0, shifter_operand_out}, {20'h0, eo});
    chk({nm, " valid"}, {31'h0, valid}, {31'h0, ev});
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset busy",  {31'h0, busy}, 32'h0);
    chk("reset done",  {31'h0, done}, 32'h0);
    chk("reset valid", {31'h0, valid}, 32'h0);
    chk("reset operand", {20'h0, shifter_operand_out}, 32'h0);

    run(32'h0000_00FF, 12'h0FF, 1'b1, FAST ? 0 : 1, "ff");
    run(32'hFF00_0000, 12'h4FF, 1'b1, 5, "ff000000");
    run(32'hF000_000F, 12'h2FF, 1'b1, 3, "f000000f");
    run(32'h0000_0104, 12'hF41, 1'b1, 16, "104");
    run(32'h0000_0101, 12'h000, 1'b0, 16, "101 unencodable");
    run(32'h0000_0FF0, 12'hEFF, 1'b1, 15, "ff0");

    // Second start during SEARCH and a start during DONE must both be ignored.
    @(negedge clk);
    start = 1'b1; value_in = 32'h0000_03FC;
    @(negedge clk);
    start = 1'b0; value_in = 32'h0;
    @(negedge clk);
    start = 1'b1; value_in = 32'h0000_FF00;
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("3fc latency", n, 16);
    chk("3fc operand", {20'h0, shifter_operand_out}, 32'hFFF);
    chk("3fc valid", {31'h0, valid}, 32'h1);
    start = 1'b1; value_in = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold busy", {31'h0, busy}, 32'h0);
    chk("hold operand", {20'h0, shifter_operand_out}, 32'hFFF);
    chk("hold valid", {31'h0, valid}, 32'h1);

    // Reset landing at E5 abandons the search without a done pulse.
    @(negedge clk);
    start = 1'b1; value_in = 32'h0000_0101;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst operand", {20'h0, shifter_operand_out}, 32'h0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("rst no done", n, 0);

    run(32'h0000_0000, 12'h000, 1'b1, FAST ? 0 : 1, "zero");
    run(32'h8000_0001, 12'h106, 1'b1, 2, "80000001");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
